// File: rtl/axil_pkg.sv
// Purpose: shared FSM state type and AXI-lite response/address constants for axil_cmd_master.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package axil_pkg;

  // Master sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RESP  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // AXI response codes; DECERR doubles as the local timeout code
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Word addressing: 32-bit words, low two byte-address bits dropped
  localparam int ADDRLSB = 2;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;

endpackage

// File: rtl/axil_watchdog.sv
// Purpose: saturating cycle counter that flags a stalled AXI-lite transaction.
// Latency: expired rises LIMIT enabled cycles after the last clear (registered count, combinational compare).
// Backpressure: none; clear has priority over enable, the count holds once expired.
module axil_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(LIMIT));

  // Count enabled cycles since the last clear, stopping at the limit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axil_cmd_master.sv
// Purpose: turns one valid/ready register command into a single AXI-lite AW/W/B or AR/R transaction.
// Latency: AXI valids one cycle after command accept; o_rsp_valid one cycle after the B/R handshake.
// Backpressure: one transaction outstanding; o_cmd_ready low until the response is taken by i_rsp_ready.
// Optional: define AXIL_MASTER_TIMEOUT_EN to add the stall watchdog, 2'b11 timeout response and sticky FAULT state.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter bit OPT_LOWPOWER     = 1'b0,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  // command
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_we,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0]           i_cmd_data,
  input  logic [STRB_W-1:0]           i_cmd_strb,
  // response
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [DATA_W-1:0]           o_rsp_data,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_fault,
  // AXI-lite write address
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  // AXI-lite write data
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  output logic [DATA_W-1:0]           M_AXI_WDATA,
  output logic [STRB_W-1:0]           M_AXI_WSTRB,
  // AXI-lite write response
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  // AXI-lite read address
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  // AXI-lite read data
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  input  logic [DATA_W-1:0]           M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int C_AXI_DATA_WIDTH = DATA_W;

  // Mask that clears the sub-word byte-address bits
  localparam logic [AW-1:0] WORD_MASK = ~{{(AW-ADDRLSB){1'b0}}, {ADDRLSB{1'b1}}};

  state_t state, next_state;

  logic                  aw_vld_q, w_vld_q, ar_vld_q;
  logic [AW-1:0]         awaddr_q, araddr_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic [1:0]            rsp_resp_q;
  logic                  fault_q;
  logic                  wd_expired;

  logic                  cmd_accept;
  logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                  timeout_fire;
  logic [AW-1:0]         cmd_addr_word;

  assign cmd_addr_word = i_cmd_addr & WORD_MASK;

  assign cmd_accept = i_cmd_valid && o_cmd_ready;
  assign aw_hs      = aw_vld_q && M_AXI_AWREADY;
  assign w_hs       = w_vld_q && M_AXI_WREADY;
  assign ar_hs      = ar_vld_q && M_AXI_ARREADY;
  // Responses drained in FAULT are discarded, so only count them in the live states
  assign b_hs       = M_AXI_BVALID && M_AXI_BREADY && (state == WRITE);
  assign r_hs       = M_AXI_RVALID && M_AXI_RREADY && (state == READ);
  // A real response arriving on the expiry cycle wins over the timeout
  assign timeout_fire = wd_expired &&
                        (((state == WRITE) && !b_hs) || ((state == READ) && !r_hs));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          next_state = i_cmd_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (b_hs || timeout_fire) begin
          next_state = RESP;
        end
      end
      READ: begin
        if (r_hs || timeout_fire) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          next_state = fault_q ? FAULT : IDLE;
        end
      end
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded handshake outputs
  always_comb begin
    o_cmd_ready  = 1'b0;
    M_AXI_BREADY = 1'b0;
    M_AXI_RREADY = 1'b0;
    o_rsp_valid  = 1'b0;
    case (state)
      IDLE:  o_cmd_ready  = !i_reset;
      WRITE: M_AXI_BREADY = 1'b1;
      READ:  M_AXI_RREADY = 1'b1;
      RESP:  o_rsp_valid  = 1'b1;
      FAULT: begin
        M_AXI_BREADY = 1'b1;
        M_AXI_RREADY = 1'b1;
      end
      default: ;
    endcase
  end

  // Channel valids: raised at accept, dropped by their own handshake or a timeout
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      aw_vld_q <= 1'b0;
      w_vld_q  <= 1'b0;
      ar_vld_q <= 1'b0;
    end else if (timeout_fire) begin
      aw_vld_q <= 1'b0;
      w_vld_q  <= 1'b0;
      ar_vld_q <= 1'b0;
    end else begin
      if (cmd_accept && i_cmd_we) begin
        aw_vld_q <= 1'b1;
        w_vld_q  <= 1'b1;
      end
      if (cmd_accept && !i_cmd_we) begin
        ar_vld_q <= 1'b1;
      end
      if (aw_hs) aw_vld_q <= 1'b0;
      if (w_hs)  w_vld_q  <= 1'b0;
      if (ar_hs) ar_vld_q <= 1'b0;
    end
  end

  // Channel payloads: captured only at accept so they stay stable while valid waits
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (cmd_accept) begin
      if (i_cmd_we) begin
        awaddr_q <= cmd_addr_word;
        wdata_q  <= i_cmd_data;
        wstrb_q  <= i_cmd_strb;
      end else begin
        araddr_q <= cmd_addr_word;
      end
    end
  end

  // Response capture; held untouched through RESP until the consumer takes it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_OKAY;
    end else if (b_hs) begin
      rsp_data_q <= '0;
      rsp_resp_q <= M_AXI_BRESP;
    end else if (r_hs) begin
      rsp_data_q <= M_AXI_RDATA;
      rsp_resp_q <= M_AXI_RRESP;
    end else if (timeout_fire) begin
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_DECERR;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  // Any forward progress on a request channel restarts the stall window
  assign wd_clear  = cmd_accept || aw_hs || w_hs || ar_hs;
  assign wd_enable = (state == WRITE) || (state == READ);

  axil_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (i_clk),
    .reset   (i_reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Sticky fault flag: only a reset clears it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fault_q <= 1'b0;
    end else if (timeout_fire) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign fault_q    = 1'b0;
`endif

  assign o_fault    = fault_q;
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_resp = rsp_resp_q;

  assign M_AXI_AWVALID = aw_vld_q;
  assign M_AXI_WVALID  = w_vld_q;
  assign M_AXI_ARVALID = ar_vld_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;

  // Low-power build keeps payload lines quiet whenever their valid is low
  assign M_AXI_AWADDR = (OPT_LOWPOWER && !aw_vld_q) ? '0 : awaddr_q;
  assign M_AXI_WDATA  = (OPT_LOWPOWER && !w_vld_q)  ? '0 : wdata_q;
  assign M_AXI_WSTRB  = (OPT_LOWPOWER && !w_vld_q)  ? '0 : wstrb_q;
  assign M_AXI_ARADDR = (OPT_LOWPOWER && !ar_vld_q) ? '0 : araddr_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Purpose: directed self-checking bench for axil_cmd_master against a small four-register AXI-lite slave model.
// Latency: expects AXI valids one cycle after accept and o_rsp_valid three cycles after accept with a zero-wait slave.
// Backpressure: slave AWREADY stall and response-side i_rsp_ready stall are both exercised.
module tb_axil_cmd_master;
  import axil_pkg::*;

  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_we;
  logic [AW-1:0] i_cmd_addr;
  logic [31:0]   i_cmd_data;
  logic [3:0]    i_cmd_strb;
  logic          o_rsp_valid, i_rsp_ready;
  logic [31:0]   o_rsp_data;
  logic [1:0]    o_rsp_resp;
  logic          o_fault;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int n_tests = 0;
  int n_fail  = 0;

  // slave model controls
  int aw_wait  = 0;
  bit b_hold   = 1'b0;
  bit ar_block = 1'b0;

  axil_cmd_master #(
    .C_AXI_ADDR_WIDTH (AW),
    .OPT_LOWPOWER     (1'b0),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_we      (i_cmd_we),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_data    (i_cmd_data),
    .i_cmd_strb    (i_cmd_strb),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_data    (o_rsp_data),
    .o_rsp_resp    (o_rsp_resp),
    .o_fault       (o_fault),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp)
  );

  // ---------------- slave model ----------------
  logic [31:0]   mem [4];
  int            aw_cnt;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_l;
  logic [31:0]   wd_l;
  logic [3:0]    ws_l;

  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid;
  assign arready = arvalid && !ar_block;

  wire        aw_hs  = awvalid && awready;
  wire        w_hs   = wvalid && wready;
  wire [1:0]  wr_idx = aw_hs ? awaddr[3:2] : aw_l[3:2];
  wire [31:0] wr_dat = w_hs ? wdata : wd_l;
  wire [3:0]  wr_stb = w_hs ? wstrb : ws_l;
  wire        wr_go  = (aw_got || aw_hs) && (w_got || w_hs) && !bvalid && !b_hold;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      aw_cnt <= 0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_l   <= '0;
      wd_l   <= '0;
      ws_l   <= '0;
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else                     aw_cnt <= 0;
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_l   <= awaddr;
      end
      if (w_hs) begin
        w_got <= 1'b1;
        wd_l  <= wdata;
        ws_l  <= wstrb;
      end
      if (wr_go) begin
        mem[wr_idx] <= merge(mem[wr_idx], wr_dat, wr_stb);
        bvalid      <= 1'b1;
        bresp       <= (wr_stb == 4'h0) ? RESP_SLVERR : RESP_OKAY;
        aw_got      <= 1'b0;
        w_got       <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= mem[araddr[3:2]];
        rresp  <= RESP_OKAY;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- bus monitor ----------------
  logic [AW-1:0] mon_awaddr, mon_araddr;
  logic [31:0]   mon_wdata;
  logic [3:0]    mon_wstrb;
  logic [2:0]    mon_prot;
  int            b_hs_cnt  = 0;
  int            stray_cnt = 0;

  always @(posedge clk) begin
    if (aw_hs) begin
      mon_awaddr <= awaddr;
      mon_prot   <= awprot;
    end
    if (w_hs) begin
      mon_wdata <= wdata;
      mon_wstrb <= wstrb;
    end
    if (arvalid && arready) begin
      mon_araddr <= araddr;
      mon_prot   <= arprot;
    end
    if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
    // a response the master is not ready for should never be presented
    if (!rst && ((bvalid && !bready) || (rvalid && !rready))) stray_cnt <= stray_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted; returns one cycle after the accept edge
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    int k;
    k = 0;
    i_cmd_we    = we;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    i_cmd_strb  = strb;
    i_cmd_valid = 1'b1;
    while (!o_cmd_ready && k < 20) begin
      tick();
      k++;
    end
    check("cmd_accept", 32'(o_cmd_ready), 32'd1);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, take it, report data/resp and cycles since accept
  task automatic wait_rsp(output logic [31:0] d, output logic [1:0] r, output int lat);
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    d = o_rsp_data;
    r = o_rsp_resp;
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] d;
  logic [1:0]  r;
  int          lat;
  int          b_before;
  int          seen;

  initial begin
    rst         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_we    = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_data  = '0;
    i_cmd_strb  = '0;
    i_rsp_ready = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    check("rst_readies", {30'd0, bready, rready}, 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_rsp_resp", 32'(o_rsp_resp), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_awaddr", 32'(awaddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", 32'(o_cmd_ready), 32'd1);

    // write 0xDEADBEEF to 0x4, then read it back
    issue(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
    check("w1_valids_c1", {30'd0, awvalid, wvalid}, 32'h3);
    check("w1_busy", 32'(o_cmd_ready), 32'd0);
    wait_rsp(d, r, lat);
    check("w1_awaddr", 32'(mon_awaddr), 32'h4);
    check("w1_wdata", mon_wdata, 32'hDEADBEEF);
    check("w1_wstrb", 32'(mon_wstrb), 32'hF);
    check("w1_prot", 32'(mon_prot), 32'd0);
    check("w1_resp", 32'(r), 32'(RESP_OKAY));
    check("w1_data_zero", d, 32'd0);
    check("w1_latency", 32'(lat), 32'd3);

    issue(1'b0, 4'h4, 32'h0, 4'h0);
    check("r1_arvalid_c1", 32'(arvalid), 32'd1);
    wait_rsp(d, r, lat);
    check("r1_araddr", 32'(mon_araddr), 32'h4);
    check("r1_data", d, 32'hDEADBEEF);
    check("r1_resp", 32'(r), 32'(RESP_OKAY));
    check("r1_latency", 32'(lat), 32'd3);

    // unaligned partial write to 0x9 merges into the word at 0x8
    issue(1'b1, 4'h8, 32'h11223344, 4'hF);
    wait_rsp(d, r, lat);
    issue(1'b1, 4'h9, 32'h0000A5A5, 4'h3);
    wait_rsp(d, r, lat);
    check("w2_awaddr_aligned", 32'(mon_awaddr), 32'h8);
    check("w2_wstrb", 32'(mon_wstrb), 32'h3);
    issue(1'b0, 4'h8, 32'h0, 4'h0);
    wait_rsp(d, r, lat);
    check("r2_merged", d, 32'h1122A5A5);

    // AWREADY stalled 3 cycles, WREADY immediate
    aw_wait  = 3;
    b_before = b_hs_cnt;
    issue(1'b1, 4'hC, 32'hCAFEF00D, 4'hF);
    check("st_c1_valids", {30'd0, awvalid, wvalid}, 32'h3);
    tick();
    check("st_c2_wvalid", 32'(wvalid), 32'd0);
    check("st_c2_awvalid", 32'(awvalid), 32'd1);
    check("st_c2_awaddr", 32'(awaddr), 32'hC);
    tick();
    check("st_c3_awvalid", 32'(awvalid), 32'd1);
    check("st_c3_awaddr", 32'(awaddr), 32'hC);
    tick();
    check("st_c4_aw_hs", {30'd0, awvalid, awready}, 32'h3);
    check("st_c4_awaddr", 32'(awaddr), 32'hC);
    tick();
    check("st_c5_awvalid", 32'(awvalid), 32'd0);
    wait_rsp(d, r, lat);
    check("st_resp", 32'(r), 32'(RESP_OKAY));
    tick();
    tick();
    check("st_one_b", 32'(b_hs_cnt - b_before), 32'd1);
    aw_wait = 0;

    // response held with i_rsp_ready low for 5 cycles
    issue(1'b0, 4'hC, 32'h0, 4'h0);
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 32'(o_rsp_valid), 32'd1);
      check("hold_rsp_data", o_rsp_data, 32'hCAFEF00D);
      check("hold_cmd_ready", 32'(o_cmd_ready), 32'd0);
      tick();
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("hold_released", 32'(o_rsp_valid), 32'd0);

    // slave error passes through as BRESP
    issue(1'b1, 4'h0, 32'h12345678, 4'h0);
    wait_rsp(d, r, lat);
    check("slverr_resp", 32'(r), 32'(RESP_SLVERR));

    // reset one cycle after the AW handshake, before any B
    b_hold = 1'b1;
    issue(1'b1, 4'h0, 32'h55555555, 4'hF);
    tick();
    check("mr_aw_done", 32'(awvalid), 32'd0);
    check("mr_bready", 32'(bready), 32'd1);
    rst = 1'b1;
    tick();
    check("mr_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    check("mr_readies", {30'd0, bready, rready}, 32'd0);
    check("mr_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("mr_rsp_data", o_rsp_data, 32'd0);
    rst    = 1'b0;
    b_hold = 1'b0;
    tick();
    check("mr_cmd_ready", 32'(o_cmd_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_rsp_valid) seen++;
      tick();
    end
    check("mr_no_rsp", 32'(seen), 32'd0);
    issue(1'b0, 4'h0, 32'h0, 4'h0);
    wait_rsp(d, r, lat);
    check("mr_recover_data", d, 32'd0);
    check("mr_recover_lat", 32'(lat), 32'd3);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // ARREADY never comes: watchdog fires and the block locks into FAULT
    ar_block = 1'b1;
    issue(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp(d, r, lat);
    check("to_latency", 32'(lat), 32'd18);
    check("to_resp", 32'(r), 32'(RESP_DECERR));
    check("to_fault", 32'(o_fault), 32'd1);
    check("to_arvalid", 32'(arvalid), 32'd0);
    check("to_drain_readies", {30'd0, bready, rready}, 32'h3);
    i_cmd_valid = 1'b1;
    i_cmd_we    = 1'b0;
    i_cmd_addr  = 4'h4;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_cmd_ready || arvalid || o_rsp_valid) seen++;
      tick();
    end
    i_cmd_valid = 1'b0;
    check("to_refused", 32'(seen), 32'd0);
    ar_block = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("to_fault_cleared", 32'(o_fault), 32'd0);
    check("to_cmd_ready", 32'(o_cmd_ready), 32'd1);
`endif

    check("stray_responses", 32'(stray_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence ever wedges
  initial begin
    #200000;
    $display("FAIL global_timeout: sequence did not complete");
    $fatal(1);
  end

endmodule
